uart_frame_arbiter: RTL and testbench
=====================================

Name: uart_frame_arbiter

Overview:
- Shares one byte-level uart_tx instance among NUM_REQ string requesters, such as measurement and report modules.
- Arbitrates round-robin and captures the winner's string.
- Emits the string as a framed packet "&&" + content + "&&", one byte per uart_tx handshake, then reports completion or timeout to the winner.
- Sits between the application modules and the uart_tx byte transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
STR_BYTES, 32, max content bytes per requester string
TIMEOUT_CLK, 200_000, max clocks waiting for uart_tx_done per byte before abort

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  level request per requester; held until req_ack
req_string  in  NUM_REQ*STR_BYTES*8  requester k occupies slice k; content byte j at bits [8j+7:8j] of the slice
req_length  in  NUM_REQ*8  requester k content length at [8k+7:8k]
req_ack  out  NUM_REQ  one-cycle pulse; string captured for that requester
req_done  out  NUM_REQ  one-cycle pulse; frame finished (or aborted) for that requester
req_err  out  1  valid with req_done; 1 = aborted by timeout
busy  out  1  high from capture cycle through DONE
cur_grant  out  3  index of current/last granted requester
uart_tx_data  out  8  byte to uart_tx
uart_tx_req  out  1  one-cycle start pulse to uart_tx
uart_tx_done  in  1  one-cycle pulse from uart_tx when byte fully sent

Behaviour:
- Reset, on a sys_clk edge with sys_rst_n low:
  - all outputs 0, state IDLE;
  - round-robin pointer = 0, so requester 0 has top priority first;
  - capture buffer and counters cleared.
- Reset mid-frame abandons the frame with no req_done. uart_tx_req drops the same cycle.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - If any req_valid, select the first set bit scanning upward from the pointer, wrapping modulo NUM_REQ.
  - On that edge, latch the winner's string and length, set cur_grant, pulse req_ack[winner], set busy, go to SEND.
  - Length > STR_BYTES clamps to STR_BYTES.
- Pointer update: the pointer becomes winner+1 (mod NUM_REQ) at capture.
- Requester behaviour after ack: a requester still holding valid after ack gets a new frame only by winning again. A requester may drop valid before ack; dropped requests are simply not served.
- Byte index b runs 0..L+3, where L is the clamped length:
  - b = 0, 1, L+2, L+3 send "&" (0x26);
  - otherwise send content byte b-2.
- SEND: drive uart_tx_data = byte b and pulse uart_tx_req for exactly one cycle. Go to WAIT with the timeout counter cleared.
- WAIT:
  - On uart_tx_done: if b == L+3 go to DONE; else b <= b+1 and go to SEND.
  - If the counter reaches TIMEOUT_CLK-1 without done: set err, go to DONE.
  - uart_tx_done while not in WAIT is ignored.
- DONE (one cycle): pulse req_done[cur_grant] with req_err = err, clear busy and err, go to IDLE.
- A request pending during DONE is arbitrated on the following IDLE cycle.
- Latency:
  - req_valid seen in IDLE → req_ack next edge;
  - first uart_tx_req one cycle after ack;
  - next byte's uart_tx_req one cycle after each uart_tx_done.
  - Frame length is always L+4 bytes. L = 0 yields "&&&&".
- Content bytes equal to "&" are transmitted unchanged; there is no escaping.
- Only one frame is in flight at a time. Input changes after capture do not affect the frame in progress.

Test Plan:
- Single request: req_valid[1], length 3, string "ABC", uart_tx model returns done 10 cycles after each req → bytes 26 26 41 42 43 26 26 in order; one req_ack[1]; req_done[1] with req_err=0; busy low after DONE.
- All four valid from reset, each length 1 → grant order 0,1,2,3; pointer then 0. Re-raise 2 and 3 together → 2 is served first only if pointer ≤ 2; check order 2 then 3 after pointer = 0.
- Length 0 and length 40 with STR_BYTES = 32 → "&&&&" (4 bytes); 36-byte frame whose content is bytes 0..31 of the string.
- Timeout: TIMEOUT_CLK=50, uart_tx_done withheld after the 3rd byte → req_done with req_err=1 exactly 50 cycles after the WAIT entry; next request is served normally.
- Reset asserted mid-content byte 5 → all outputs 0 the next cycle, no req_done, and the pointer restarts at 0.
- Spurious uart_tx_done in IDLE, plus string input changed after req_ack → no byte advance; transmitted content matches the captured value.

Source files
------------

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that shares one byte-level uart_tx among NUM_REQ string sources.
// Each granted string goes out as "&&" + content + "&&", one byte per uart_tx handshake.
module uart_frame_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int STR_BYTES   = 32,
  parameter int TIMEOUT_CLK = 200_000
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*STR_BYTES*8-1:0] req_string,
  input  logic [NUM_REQ*8-1:0]           req_length,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           req_err,
  output logic                           busy,
  output logic [2:0]                     cur_grant,
  output logic [7:0]                     uart_tx_data,
  output logic                           uart_tx_req,
  input  logic                           uart_tx_done
);
  localparam int BW = 9;
  localparam int IW = (STR_BYTES > 1) ? $clog2(STR_BYTES) : 1;
  localparam int CW = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;
  localparam logic [7:0] AMP = 8'h26;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  typedef struct packed {
    logic [BW-1:0]                len;
    logic [STR_BYTES-1:0][7:0]    data;
  } frame_t;

  state_t        state;
  frame_t        frm;
  logic [2:0]    ptr;
  logic [BW-1:0] bidx;
  logic [CW-1:0] tcnt;

  logic [NUM_REQ-1:0][STR_BYTES-1:0][7:0] str_v;
  logic [NUM_REQ-1:0][7:0]                len_v;

  assign str_v = req_string;
  assign len_v = req_length;

  // Round-robin scan starting at ptr, wrapping modulo NUM_REQ.
  logic found;
  int   wi;
  int   k;
  always_comb begin
    found = 1'b0;
    wi    = 0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req_valid[k]) begin
        found = 1'b1;
        wi    = k;
      end
    end
  end

  logic [BW-1:0] len_sel;
  always_comb begin
    len_sel = {1'b0, len_v[wi]};
    if (len_sel > BW'(STR_BYTES)) len_sel = BW'(STR_BYTES);
  end

  // Byte b of the frame: two delimiters, L content bytes, two delimiters.
  logic [BW-1:0] off;
  logic [7:0]    byte_nx;
  logic          last_byte;
  always_comb begin
    off       = bidx - BW'(2);
    last_byte = (bidx == frm.len + BW'(3));
    if (bidx < BW'(2) || bidx >= frm.len + BW'(2)) byte_nx = AMP;
    else                                           byte_nx = frm.data[off[IW-1:0]];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      frm          <= '0;
      ptr          <= '0;
      bidx         <= '0;
      tcnt         <= '0;
      req_ack      <= '0;
      req_done     <= '0;
      req_err      <= 1'b0;
      busy         <= 1'b0;
      cur_grant    <= '0;
      uart_tx_data <= '0;
      uart_tx_req  <= 1'b0;
    end else begin
      req_ack     <= '0;
      req_done    <= '0;
      req_err     <= 1'b0;
      uart_tx_req <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            frm.data  <= str_v[wi];
            frm.len   <= len_sel;
            cur_grant <= 3'(wi);
            req_ack   <= NUM_REQ'(1) << wi;
            ptr       <= (wi == NUM_REQ - 1) ? 3'd0 : 3'(wi + 1);
            busy      <= 1'b1;
            bidx      <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          uart_tx_data <= byte_nx;
          uart_tx_req  <= 1'b1;
          tcnt         <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          // A completed byte wins over a coincident timeout.
          if (uart_tx_done) begin
            if (last_byte) begin
              req_done <= NUM_REQ'(1) << cur_grant;
              state    <= DONE;
            end else begin
              bidx  <= bidx + BW'(1);
              state <= SEND;
            end
          end else if (tcnt == CW'(TIMEOUT_CLK - 1)) begin
            req_done <= NUM_REQ'(1) << cur_grant;
            req_err  <= 1'b1;
            state    <= DONE;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter with a delayed-done uart_tx model.
module tb_uart_frame_arbiter;
  localparam int NR  = 4;
  localparam int SB  = 32;
  localparam int TO  = 50;
  localparam int DLY = 10;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*SB*8-1:0] req_string = '0;
  logic [NR*8-1:0]   req_length = '0;
  logic [NR-1:0]     req_ack, req_done;
  logic              req_err, busy, uart_tx_req, uart_tx_done;
  logic [2:0]        cur_grant;
  logic [7:0]        uart_tx_data;
  logic              model_done = 1'b0;
  logic              spur_done = 1'b0;

  int checks = 0, failures = 0, cyc = 0, dcnt = 0, hold_at = -1;
  logic [7:0] rx_q[$];
  int         req_cyc[$], grant_q[$], ack_cyc[$], done_idx[$], done_cyc[$];
  logic       done_err[$];

  assign uart_tx_done = model_done | spur_done;

  uart_frame_arbiter #(.NUM_REQ(NR), .STR_BYTES(SB), .TIMEOUT_CLK(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_string(req_string), .req_length(req_length),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
    .busy(busy), .cur_grant(cur_grant),
    .uart_tx_data(uart_tx_data), .uart_tx_req(uart_tx_req), .uart_tx_done(uart_tx_done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // uart_tx model and event log; done comes DLY negedges after each request
  always @(negedge sys_clk) begin
    model_done = 1'b0;
    if (!sys_rst_n) dcnt = 0;
    else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) model_done = 1'b1;
      end
      if (uart_tx_req) begin
        rx_q.push_back(uart_tx_data);
        req_cyc.push_back(cyc);
        if (rx_q.size() != hold_at) dcnt = DLY;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ack[i]) begin grant_q.push_back(i); ack_cyc.push_back(cyc); end
      if (req_done[i]) begin done_idx.push_back(i); done_err.push_back(req_err); done_cyc.push_back(cyc); end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic put_byte(input int r, input int j, input logic [7:0] v);
    req_string[(r*SB+j)*8 +: 8] = v;
  endtask

  task automatic put_str(input int r, input string s);
    for (int j = 0; j < s.len(); j++) put_byte(r, j, s[j]);
  endtask

  task automatic set_len(input int r, input int l);
    req_length[r*8 +: 8] = 8'(l);
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  function automatic int first_diff(input int base, input logic [7:0] exp[$]);
    if (rx_q.size() - base != exp.size()) return -2;
    for (int i = 0; i < exp.size(); i++) if (rx_q[base+i] !== exp[i]) return i;
    return -1;
  endfunction

  task automatic run_frames(input int n, input string tag);
    int tgt = done_idx.size() + n;
    int t = 0;
    while (done_idx.size() < tgt && t < 4000) begin
      @(negedge sys_clk); #1;
      t++;
      req_valid = req_valid & ~req_ack;
    end
    if (done_idx.size() < tgt) begin
      checks++; failures++;
      $display("FAIL %s_wait got %0d done pulses, need %0d", tag, done_idx.size(), tgt);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    checks++; if (req_ack !== '0)      begin failures++; $display("FAIL rst_ack got %b need 0", req_ack); end
    checks++; if (req_done !== '0)     begin failures++; $display("FAIL rst_done got %b need 0", req_done); end
    checks++; if (req_err !== 1'b0)    begin failures++; $display("FAIL rst_err got %b need 0", req_err); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got %b need 0", busy); end
    checks++; if (cur_grant !== 3'd0)  begin failures++; $display("FAIL rst_grant got %0d need 0", cur_grant); end
    checks++; if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL rst_data got %h need 00", uart_tx_data); end
    checks++; if (uart_tx_req !== 1'b0) begin failures++; $display("FAIL rst_txreq got %b need 0", uart_tx_req); end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single();
    int b0 = rx_q.size(), g0 = grant_q.size(), d0 = done_idx.size(), c0, d;
    logic [7:0] exp[$];
    put_str(1, "ABC"); set_len(1, 3);
    c0 = cyc;
    req_valid[1] = 1'b1;
    run_frames(1, "single");
    exp = {8'h26, 8'h26, 8'h41, 8'h42, 8'h43, 8'h26, 8'h26};
    d = first_diff(b0, exp);
    checks++; if (d != -1) begin failures++; $display("FAIL single_bytes diff_at=%0d got_len=%0d need_len=7", d, rx_q.size()-b0); end
    checks++; if (grant_q.size() - g0 != 1 || grant_q[g0] != 1) begin failures++; $display("FAIL single_ack got %0d acks, need one for 1", grant_q.size()-g0); end
    checks++; if (ack_cyc.size() <= g0 || ack_cyc[g0] != c0 + 1) begin failures++; $display("FAIL single_ack_lat got cyc %0d need %0d", (ack_cyc.size() > g0) ? ack_cyc[g0] : -1, c0+1); end
    checks++; if (req_cyc.size() < b0 + 2 || ack_cyc.size() <= g0 || req_cyc[b0] != ack_cyc[g0] + 1) begin failures++; $display("FAIL single_first_req_lat"); end
    checks++; if (req_cyc.size() < b0 + 2 || req_cyc[b0+1] - req_cyc[b0] != DLY + 2) begin failures++; $display("FAIL single_byte_gap got %0d need %0d", (req_cyc.size() >= b0+2) ? req_cyc[b0+1]-req_cyc[b0] : -1, DLY+2); end
    checks++; if (done_idx.size() <= d0 || done_idx[d0] != 1 || done_err[d0] !== 1'b0) begin failures++; $display("FAIL single_done wrong index or err"); end
    @(negedge sys_clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got %b need 0", busy); end
  endtask

  task automatic test_round_robin();
    int b0, g0, d;
    logic [7:0] exp[$];
    int eo[$];
    pulse_reset();
    for (int r = 0; r < NR; r++) begin put_byte(r, 0, 8'h60 + 8'(r)); set_len(r, 1); end
    b0 = rx_q.size(); g0 = grant_q.size();
    req_valid = 4'hF;
    run_frames(4, "rr4");
    eo = {0, 1, 2, 3};
    d = 0;
    for (int i = 0; i < 4; i++) if (grant_q.size() <= g0 + i || grant_q[g0+i] != eo[i]) d = 1;
    checks++; if (d != 0) begin failures++; $display("FAIL rr_order4 got %0d grants, need order 0,1,2,3", grant_q.size()-g0); end
    exp = {};
    for (int r = 0; r < NR; r++) exp = {exp, 8'h26, 8'h26, 8'h60 + 8'(r), 8'h26, 8'h26};
    d = first_diff(b0, exp);
    checks++; if (d != -1) begin failures++; $display("FAIL rr_bytes diff_at=%0d", d); end
    g0 = grant_q.size();
    req_valid = 4'b1100;
    run_frames(2, "rr23");
    checks++; if (grant_q.size() - g0 != 2 || grant_q[g0] != 2 || grant_q[g0+1] != 3) begin failures++; $display("FAIL rr_order23 need 2 then 3"); end
    req_valid = 4'b0100;
    run_frames(1, "rr2");
    g0 = grant_q.size();
    req_valid = 4'b1010;
    run_frames(2, "rrwrap");
    checks++; if (grant_q.size() - g0 != 2 || grant_q[g0] != 3 || grant_q[g0+1] != 1) begin failures++; $display("FAIL rr_wrap need 3 then 1"); end
  endtask

  task automatic test_length();
    int b0, d;
    logic [7:0] exp[$];
    set_len(0, 0);
    b0 = rx_q.size();
    req_valid = 4'b0001;
    run_frames(1, "len0");
    exp = {8'h26, 8'h26, 8'h26, 8'h26};
    d = first_diff(b0, exp);
    checks++; if (d != -1) begin failures++; $display("FAIL len0_bytes diff_at=%0d got_len=%0d need_len=4", d, rx_q.size()-b0); end
    for (int j = 0; j < 40; j++) put_byte(3, j, (j == 5) ? 8'h26 : 8'h30 + 8'(j));
    set_len(3, 40);
    b0 = rx_q.size();
    req_valid = 4'b1000;
    run_frames(1, "len40");
    exp = {8'h26, 8'h26};
    for (int j = 0; j < SB; j++) exp.push_back((j == 5) ? 8'h26 : 8'h30 + 8'(j));
    exp = {exp, 8'h26, 8'h26};
    d = first_diff(b0, exp);
    checks++; if (d != -1) begin failures++; $display("FAIL len40_bytes diff_at=%0d got_len=%0d need_len=36", d, rx_q.size()-b0); end
  endtask

  task automatic test_timeout();
    int b0 = rx_q.size(), d0 = done_idx.size(), d;
    logic [7:0] exp[$];
    put_str(2, "TIME"); set_len(2, 4);
    hold_at = b0 + 3;
    req_valid = 4'b0100;
    run_frames(1, "timeout");
    checks++; if (done_idx.size() <= d0 || done_idx[d0] != 2 || done_err[d0] !== 1'b1) begin failures++; $display("FAIL to_err need done for 2 with err=1"); end
    checks++; if (done_cyc.size() <= d0 || req_cyc.size() < b0 + 3 || done_cyc[d0] - req_cyc[b0+2] != TO) begin failures++; $display("FAIL to_latency got %0d need %0d", (done_cyc.size() > d0 && req_cyc.size() >= b0+3) ? done_cyc[d0]-req_cyc[b0+2] : -1, TO); end
    exp = {8'h26, 8'h26, 8'h54};
    d = first_diff(b0, exp);
    checks++; if (d != -1) begin failures++; $display("FAIL to_bytes diff_at=%0d", d); end
    hold_at = -1;
    put_str(2, "Z"); set_len(2, 1);
    b0 = rx_q.size(); d0 = done_idx.size();
    req_valid = 4'b0100;
    run_frames(1, "after_to");
    exp = {8'h26, 8'h26, 8'h5A, 8'h26, 8'h26};
    d = first_diff(b0, exp);
    checks++; if (d != -1 || done_idx.size() <= d0 || done_err[d0] !== 1'b0) begin failures++; $display("FAIL after_to_frame diff_at=%0d", d); end
  endtask

  task automatic test_reset_mid();
    int b0 = rx_q.size(), d0, g0, t = 0;
    put_str(1, "01234567"); set_len(1, 8);
    req_valid = 4'b0010;
    while (rx_q.size() < b0 + 7 && t < 1000) begin
      @(negedge sys_clk); #1;
      t++;
      req_valid = req_valid & ~req_ack;
    end
    checks++; if (rx_q.size() < b0 + 7) begin failures++; $display("FAIL rstmid_reach got %0d bytes need 7", rx_q.size()-b0); end
    d0 = done_idx.size();
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b0;
    @(negedge sys_clk); #1;
    checks++; if ({req_ack, req_done, req_err, busy, cur_grant, uart_tx_data, uart_tx_req} !== '0) begin failures++; $display("FAIL rstmid_outs busy=%b txreq=%b data=%h grant=%0d", busy, uart_tx_req, uart_tx_data, cur_grant); end
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    #1;
    checks++; if (done_idx.size() != d0) begin failures++; $display("FAIL rstmid_nodone got %0d extra done", done_idx.size()-d0); end
    put_str(0, "a"); set_len(0, 1);
    put_str(3, "d"); set_len(3, 1);
    g0 = grant_q.size();
    req_valid = 4'b1001;
    run_frames(2, "rstmid_ptr");
    checks++; if (grant_q.size() - g0 != 2 || grant_q[g0] != 0 || grant_q[g0+1] != 3) begin failures++; $display("FAIL rstmid_ptr need 0 then 3"); end
  endtask

  task automatic test_spurious();
    int b0 = rx_q.size(), t = 0, d;
    logic [7:0] exp[$];
    spur_done = 1'b1;
    @(negedge sys_clk); #1;
    spur_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    checks++; if (rx_q.size() != b0 || busy !== 1'b0 || uart_tx_req !== 1'b0) begin failures++; $display("FAIL spur_idle got %0d bytes busy=%b", rx_q.size()-b0, busy); end
    put_str(2, "QRS"); set_len(2, 3);
    req_valid = 4'b0100;
    while (req_ack[2] !== 1'b1 && t < 20) begin @(negedge sys_clk); #1; t++; end
    checks++; if (req_ack[2] !== 1'b1) begin failures++; $display("FAIL spur_ack got %b need 1", req_ack[2]); end
    req_valid = '0;
    put_str(2, "xyz"); set_len(2, 1);
    spur_done = 1'b1;
    @(negedge sys_clk); #1;
    spur_done = 1'b0;
    run_frames(1, "spur");
    exp = {8'h26, 8'h26, 8'h51, 8'h52, 8'h53, 8'h26, 8'h26};
    d = first_diff(b0, exp);
    checks++; if (d != -1) begin failures++; $display("FAIL spur_bytes diff_at=%0d got_len=%0d need_len=7", d, rx_q.size()-b0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_length();
    test_timeout();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
